// File: rtl/ysyx_24100005_lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package ysyx_24100005_lsu_pkg;

  // RISC-V load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  // lg is log2 of the access size in bytes; sext selects sign extension on loads
  typedef struct packed {
    logic       legal;
    logic       sext;
    logic [1:0] lg;
  } size_dec_t;

  // Decode funct3 into access size / extension and flag encodings the core cannot issue
  function automatic size_dec_t size_decode(input logic [2:0] f3, input logic we, input logic is64);
    size_dec_t d;
    d = '0;
    case (f3)
      F3_B:    d = '{legal: 1'b1,        sext: 1'b1, lg: 2'd0};
      F3_H:    d = '{legal: 1'b1,        sext: 1'b1, lg: 2'd1};
      F3_W:    d = '{legal: 1'b1,        sext: 1'b1, lg: 2'd2};
      F3_D:    d = '{legal: is64,        sext: 1'b1, lg: 2'd3};
      F3_BU:   d = '{legal: ~we,         sext: 1'b0, lg: 2'd0};
      F3_HU:   d = '{legal: ~we,         sext: 1'b0, lg: 2'd1};
      F3_WU:   d = '{legal: ~we & is64,  sext: 1'b0, lg: 2'd2};
      default: d = '0;
    endcase
    return d;
  endfunction

  // True when the byte lane is not a multiple of the access size
  function automatic logic misaligned(input logic [2:0] lane, input logic [1:0] lg);
    logic [2:0] low_mask;
    low_mask = (3'd1 << lg) - 3'd1;
    return (lane & low_mask) != 3'd0;
  endfunction

endpackage

// File: rtl/ysyx_24100005_lsu_if.sv
// Core request/response and memory request/response signals of the LSU.
// slave: the LSU's view. master: the core + memory environment's view.
interface ysyx_24100005_lsu_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned NBYTE = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [NBYTE-1:0]  mem_wmask;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
           mem_req_ready, mem_resp_valid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
           mem_req_ready, mem_resp_valid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/ysyx_24100005_lsu_align.sv
// Byte-lane alignment: load extract + sign/zero extend, store shift + strobe generation.
module ysyx_24100005_lsu_align #(
  parameter int unsigned XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] ld_lane,
  input  logic [1:0]                ld_lg,
  input  logic                      ld_sext,
  input  logic [XLEN-1:0]           ld_word,
  output logic [XLEN-1:0]           ld_data_c,
  input  logic [$clog2(XLEN/8)-1:0] st_lane,
  input  logic [1:0]                st_lg,
  input  logic [XLEN-1:0]           st_wdata,
  output logic [XLEN-1:0]           st_data_c,
  output logic [XLEN/8-1:0]         st_mask_c
);
  localparam int unsigned NBYTE = XLEN / 8;
  localparam int unsigned XW    = $clog2(XLEN);

  logic [XLEN-1:0] shifted;
  logic            sign;
  int              nbits;

  // Shift the addressed lane down to bit 0, then extend above the access width
  always_comb begin
    ld_data_c = '0;
    shifted   = ld_word >> {ld_lane, 3'b000};
    nbits     = 8 << ld_lg;
    if (nbits > int'(XLEN)) nbits = int'(XLEN);
    sign      = ld_sext & shifted[XW'(nbits - 1)];
    for (int i = 0; i < int'(XLEN); i++) begin
      ld_data_c[i] = (i < nbits) ? shifted[i] : sign;
    end
  end

  // Move store data up to its lane; strobes are cut off at the word boundary
  always_comb begin
    st_data_c = st_wdata << {st_lane, 3'b000};
    st_mask_c = '0;
    for (int i = 0; i < int'(NBYTE); i++) begin
      st_mask_c[i] = (i >= int'(st_lane)) && (i < int'(st_lane) + (1 << st_lg));
    end
  end

endmodule

// File: rtl/ysyx_24100005_lsu.sv
// Multi-cycle load/store unit: one core request -> one word-aligned memory
// request -> one response. Optional macro LSU_MISALIGN_TRAP_EN traps
// size-misaligned accesses without touching memory.
module ysyx_24100005_lsu
  import ysyx_24100005_lsu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input logic clk,
  input logic rst,
  ysyx_24100005_lsu_if.slave bus
);
  localparam int unsigned NBYTE = XLEN / 8;
  localparam int unsigned LW    = $clog2(NBYTE);
  localparam logic        IS64  = (XLEN == 64);

  lsu_state_t    state;
  logic [LW-1:0] lane_q;
  logic [1:0]    lg_q;
  logic          sext_q;
  logic          we_q;

  size_dec_t       dec_c;
  logic [LW-1:0]   req_lane_c;
  logic            misal_c;
  logic            trap_c;
  logic [XLEN-1:0] ld_data_c;
  logic [XLEN-1:0] st_data_c;
  logic [NBYTE-1:0] st_mask_c;

  assign req_lane_c = bus.req_addr[LW-1:0];
  assign dec_c      = size_decode(bus.req_funct3, bus.req_we, IS64);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misal_c = misaligned(3'(req_lane_c), dec_c.lg);
`else
  assign misal_c = 1'b0;
`endif

  assign trap_c = !dec_c.legal || misal_c;

  ysyx_24100005_lsu_align #(.XLEN(XLEN)) u_align (
    .ld_lane   (lane_q),
    .ld_lg     (lg_q),
    .ld_sext   (sext_q),
    .ld_word   (bus.mem_rdata),
    .ld_data_c (ld_data_c),
    .st_lane   (req_lane_c),
    .st_lg     (dec_c.lg),
    .st_wdata  (bus.req_wdata),
    .st_data_c (st_data_c),
    .st_mask_c (st_mask_c)
  );

  // Transaction FSM; every core- and memory-facing output is a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      lane_q            <= '0;
      lg_q              <= '0;
      sext_q            <= 1'b0;
      we_q              <= 1'b0;
      bus.req_ready     <= 1'b1;
      bus.resp_valid    <= 1'b0;
      bus.resp_err      <= 1'b0;
      bus.resp_rdata    <= '0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_we        <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_wdata     <= '0;
      bus.mem_wmask     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lane_q        <= req_lane_c;
            lg_q          <= dec_c.lg;
            sext_q        <= dec_c.sext;
            we_q          <= bus.req_we;
            bus.req_ready <= 1'b0;
            if (trap_c) begin
              // Faulting request never reaches memory
              state          <= DONE;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else begin
              state             <= REQ;
              bus.mem_req_valid <= 1'b1;
              bus.mem_we        <= bus.req_we;
              bus.mem_addr      <= {bus.req_addr[ADDR_W-1:LW], LW'(0)};
              bus.mem_wdata     <= bus.req_we ? st_data_c : '0;
              bus.mem_wmask     <= bus.req_we ? st_mask_c : '0;
            end
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            state             <= WAIT;
            bus.mem_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.mem_resp_valid) begin
            state          <= DONE;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= we_q ? '0 : ld_data_c;
          end
        end
        DONE: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Directed bench for the LSU: a 32-bit and a 64-bit instance share one stimulus set.
module tb_ysyx_24100005_lsu;
  import ysyx_24100005_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_24100005_lsu_if #(.XLEN(32), .ADDR_W(32)) b32 ();
  ysyx_24100005_lsu_if #(.XLEN(64), .ADDR_W(32)) b64 ();

  ysyx_24100005_lsu #(.XLEN(32), .ADDR_W(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  ysyx_24100005_lsu #(.XLEN(64), .ADDR_W(32)) dut64 (.clk(clk), .rst(rst), .bus(b64.slave));

  // Shared stimulus; sel64 routes the request to one instance and selects what is observed
  logic        sel64;
  logic        t_req_valid, t_we, t_resp_ready, t_mem_req_ready, t_mem_resp_valid;
  logic [2:0]  t_f3;
  logic [31:0] t_addr;
  logic [63:0] t_wdata, t_mem_rdata;

  assign b32.req_valid      = t_req_valid & ~sel64;
  assign b32.req_we         = t_we;
  assign b32.req_funct3     = t_f3;
  assign b32.req_addr       = t_addr;
  assign b32.req_wdata      = t_wdata[31:0];
  assign b32.resp_ready     = t_resp_ready;
  assign b32.mem_req_ready  = t_mem_req_ready;
  assign b32.mem_resp_valid = t_mem_resp_valid;
  assign b32.mem_rdata      = t_mem_rdata[31:0];

  assign b64.req_valid      = t_req_valid & sel64;
  assign b64.req_we         = t_we;
  assign b64.req_funct3     = t_f3;
  assign b64.req_addr       = t_addr;
  assign b64.req_wdata      = t_wdata;
  assign b64.resp_ready     = t_resp_ready;
  assign b64.mem_req_ready  = t_mem_req_ready;
  assign b64.mem_resp_valid = t_mem_resp_valid;
  assign b64.mem_rdata      = t_mem_rdata;

  logic        o_req_ready, o_resp_valid, o_resp_err, o_mem_req_valid, o_mem_we;
  logic [63:0] o_resp_rdata, o_mem_wdata;
  logic [31:0] o_mem_addr;
  logic [7:0]  o_mem_wmask;

  always_comb begin
    if (sel64) begin
      o_req_ready     = b64.req_ready;
      o_resp_valid    = b64.resp_valid;
      o_resp_err      = b64.resp_err;
      o_resp_rdata    = b64.resp_rdata;
      o_mem_req_valid = b64.mem_req_valid;
      o_mem_we        = b64.mem_we;
      o_mem_addr      = b64.mem_addr;
      o_mem_wdata     = b64.mem_wdata;
      o_mem_wmask     = b64.mem_wmask;
    end else begin
      o_req_ready     = b32.req_ready;
      o_resp_valid    = b32.resp_valid;
      o_resp_err      = b32.resp_err;
      o_resp_rdata    = 64'(b32.resp_rdata);
      o_mem_req_valid = b32.mem_req_valid;
      o_mem_we        = b32.mem_we;
      o_mem_addr      = b32.mem_addr;
      o_mem_wdata     = 64'(b32.mem_wdata);
      o_mem_wmask     = 8'(b32.mem_wmask);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        wide;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] mword;
    logic [63:0] exp_rdata;
    logic        exp_err;
    logic        access;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_wmask;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic wide, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] mword,
                              input logic [63:0] erd, input logic err, input logic acc,
                              input logic [63:0] ewd, input logic [7:0] emask);
    vec_t v;
    v.name = n; v.wide = wide; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.mword = mword; v.exp_rdata = erd; v.exp_err = err; v.access = acc;
    v.exp_wdata = ewd; v.exp_wmask = emask;
    return v;
  endfunction

  // One full transaction with an immediately-ready memory and core
  task automatic run_vec(input vec_t v);
    int          lat;
    logic        saw;
    logic [31:0] exp_addr;
    sel64 = v.wide;
    exp_addr = v.addr & (v.wide ? 32'hFFFF_FFF8 : 32'hFFFF_FFFC);
    @(negedge clk);
    chk({v.name, " req_ready"}, 64'(o_req_ready), 64'd1);
    t_req_valid = 1'b1; t_we = v.we; t_f3 = v.f3; t_addr = v.addr; t_wdata = v.wdata;
    @(negedge clk);
    t_req_valid = 1'b0;
    lat = 1;
    saw = 1'b0;
    while (!o_resp_valid && lat < 20) begin
      if (o_mem_req_valid) begin
        saw = 1'b1;
        chk({v.name, " mem_addr"},  64'(o_mem_addr), 64'(exp_addr));
        chk({v.name, " mem_we"},    64'(o_mem_we), 64'(v.we));
        chk({v.name, " mem_wdata"}, o_mem_wdata, v.exp_wdata);
        chk({v.name, " mem_wmask"}, 64'(o_mem_wmask), 64'(v.exp_wmask));
        t_mem_req_ready = 1'b1;
        @(negedge clk);
        t_mem_req_ready = 1'b0;
        lat++;
        t_mem_resp_valid = 1'b1;
        t_mem_rdata = v.mword;
        @(negedge clk);
        t_mem_resp_valid = 1'b0;
        lat++;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    chk({v.name, " resp_valid"}, 64'(o_resp_valid), 64'd1);
    chk({v.name, " mem_access"}, 64'(saw), 64'(v.access));
    if (v.access) chk({v.name, " latency"}, 64'(lat), 64'd3);
    else          chk({v.name, " latency<=2"}, 64'(lat <= 2), 64'd1);
    chk({v.name, " resp_rdata"}, o_resp_rdata, v.exp_rdata);
    chk({v.name, " resp_err"}, 64'(o_resp_err), 64'(v.exp_err));
    t_resp_ready = 1'b1;
    @(negedge clk);
    t_resp_ready = 1'b0;
    chk({v.name, " idle req_ready"}, 64'(o_req_ready), 64'd1);
    chk({v.name, " idle resp_valid"}, 64'(o_resp_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    sel64 = 1'b0;
    t_req_valid = 0; t_we = 0; t_resp_ready = 0; t_mem_req_ready = 0; t_mem_resp_valid = 0;
    t_f3 = 3'd0; t_addr = '0; t_wdata = '0; t_mem_rdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset req_ready",     64'(o_req_ready), 64'd1);
    chk("reset resp_valid",    64'(o_resp_valid), 64'd0);
    chk("reset resp_err",      64'(o_resp_err), 64'd0);
    chk("reset resp_rdata",    o_resp_rdata, 64'd0);
    chk("reset mem_req_valid", 64'(o_mem_req_valid), 64'd0);
    chk("reset mem_wmask",     64'(o_mem_wmask), 64'd0);
    rst = 1'b0;

    // name, wide, we, f3, addr, wdata, mword, exp_rdata, err, access, exp_wdata, exp_wmask
    vecs.push_back(mk("lb01",   0, 0, F3_B,  32'h1001, 0, 64'h8070F0A5, 64'hFFFFFFF0, 0, 1, 0, 8'h0));
    vecs.push_back(mk("lbu01",  0, 0, F3_BU, 32'h1001, 0, 64'h8070F0A5, 64'h000000F0, 0, 1, 0, 8'h0));
    vecs.push_back(mk("lh02",   0, 0, F3_H,  32'h1002, 0, 64'h8070F0A5, 64'hFFFF8070, 0, 1, 0, 8'h0));
    vecs.push_back(mk("lhu02",  0, 0, F3_HU, 32'h1002, 0, 64'h8070F0A5, 64'h00008070, 0, 1, 0, 8'h0));
    vecs.push_back(mk("lw00",   0, 0, F3_W,  32'h1000, 0, 64'h8070F0A5, 64'h8070F0A5, 0, 1, 0, 8'h0));
    vecs.push_back(mk("lb00",   0, 0, F3_B,  32'h1000, 0, 64'h8070F0A5, 64'hFFFFFFA5, 0, 1, 0, 8'h0));
    vecs.push_back(mk("lbu03",  0, 0, F3_BU, 32'h1003, 0, 64'h8070F0A5, 64'h00000080, 0, 1, 0, 8'h0));
    vecs.push_back(mk("sh02",   0, 1, F3_H,  32'h1002, 64'h1234ABCD, 0, 0, 0, 1, 64'hABCD0000, 8'hC));
    vecs.push_back(mk("sb03",   0, 1, F3_B,  32'h1003, 64'h11223344, 0, 0, 0, 1, 64'h44000000, 8'h8));
    vecs.push_back(mk("sw04",   0, 1, F3_W,  32'h1004, 64'hDEADBEEF, 0, 0, 0, 1, 64'hDEADBEEF, 8'hF));
    vecs.push_back(mk("ill111", 0, 0, 3'b111, 32'h1000, 0, 0, 0, 1, 0, 0, 8'h0));
    vecs.push_back(mk("ill_st100", 0, 1, 3'b100, 32'h1000, 64'h55, 0, 0, 1, 0, 0, 8'h0));
    vecs.push_back(mk("ill_ld32",  0, 0, F3_D,  32'h1000, 0, 0, 0, 1, 0, 0, 8'h0));
    vecs.push_back(mk("ill_lwu32", 0, 0, F3_WU, 32'h1000, 0, 0, 0, 1, 0, 0, 8'h0));
    vecs.push_back(mk("ld00",   1, 0, F3_D,  32'h4000, 0, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 0, 1, 0, 8'h0));
    vecs.push_back(mk("lwu04",  1, 0, F3_WU, 32'h4004, 0, 64'h80000000_12345678, 64'h0000000080000000, 0, 1, 0, 8'h0));
    vecs.push_back(mk("lw04",   1, 0, F3_W,  32'h4004, 0, 64'h80000000_12345678, 64'hFFFFFFFF80000000, 0, 1, 0, 8'h0));
    vecs.push_back(mk("lh06",   1, 0, F3_H,  32'h4006, 0, 64'h80000000_12345678, 64'hFFFFFFFFFFFF8000, 0, 1, 0, 8'h0));
    vecs.push_back(mk("sd08",   1, 1, F3_D,  32'h4008, 64'h1122334455667788, 0, 0, 0, 1, 64'h1122334455667788, 8'hFF));
    vecs.push_back(mk("sw04_64",1, 1, F3_W,  32'h4004, 64'hAABBCCDD, 0, 0, 0, 1, 64'hAABBCCDD_00000000, 8'hF0));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk("mis_lw06", 1, 0, F3_W, 32'h4006, 0, 64'h80000000_12345678, 0, 1, 0, 0, 8'h0));
    vecs.push_back(mk("mis_ld04", 1, 0, F3_D, 32'h4004, 0, 64'h80000000_12345678, 0, 1, 0, 0, 8'h0));
    vecs.push_back(mk("mis_lw02", 0, 0, F3_W, 32'h1002, 0, 64'h8070F0A5, 0, 1, 0, 0, 8'h0));
    vecs.push_back(mk("mis_sh03", 0, 1, F3_H, 32'h1003, 64'h1234ABCD, 0, 0, 1, 0, 0, 8'h0));
`else
    vecs.push_back(mk("mis_lw06", 1, 0, F3_W, 32'h4006, 0, 64'h80000000_12345678, 64'h8000, 0, 1, 0, 8'h0));
    vecs.push_back(mk("mis_ld04", 1, 0, F3_D, 32'h4004, 0, 64'h80000000_12345678, 64'h0000000080000000, 0, 1, 0, 8'h0));
    vecs.push_back(mk("mis_lw02", 0, 0, F3_W, 32'h1002, 0, 64'h8070F0A5, 64'h00008070, 0, 1, 0, 8'h0));
    vecs.push_back(mk("mis_sh03", 0, 1, F3_H, 32'h1003, 64'h1234ABCD, 0, 0, 0, 1, 64'hCD000000, 8'h8));
`endif

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: slow mem_req_ready, stray response in REQ, slow resp_ready
    sel64 = 1'b0;
    @(negedge clk);
    t_req_valid = 1'b1; t_we = 1'b0; t_f3 = F3_H; t_addr = 32'h2002;
    @(negedge clk);
    t_req_valid = 1'b0;
    chk("bp mem_req_valid", 64'(o_mem_req_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      t_mem_resp_valid = (k == 2);
      t_mem_rdata = 64'hFFFFFFFF;
      @(negedge clk);
      ok = o_mem_req_valid && (o_mem_addr == 32'h2000) && !o_mem_we && (o_mem_wmask == 8'h0)
           && (o_mem_wdata == 64'h0) && !o_req_ready && !o_resp_valid;
      chk($sformatf("bp req hold %0d", k), 64'(ok), 64'd1);
    end
    t_mem_resp_valid = 1'b0;
    t_mem_req_ready = 1'b1;
    @(negedge clk);
    t_mem_req_ready = 1'b0;
    chk("bp mem_req_valid dropped", 64'(o_mem_req_valid), 64'd0);
    t_mem_rdata = 64'h8070F0A5;
    @(negedge clk);
    chk("bp wait no resp", 64'(o_resp_valid), 64'd0);
    t_mem_resp_valid = 1'b1;
    @(negedge clk);
    t_mem_resp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ok = o_resp_valid && (o_resp_rdata == 64'hFFFF8070) && !o_resp_err && !o_req_ready;
      chk($sformatf("bp resp hold %0d", k), 64'(ok), 64'd1);
      t_mem_resp_valid = (k == 1);
      t_mem_rdata = 64'h0;
      @(negedge clk);
    end
    t_mem_resp_valid = 1'b0;
    t_resp_ready = 1'b1;
    @(negedge clk);
    t_resp_ready = 1'b0;
    chk("bp resp consumed", 64'(o_resp_valid), 64'd0);
    chk("bp req_ready back", 64'(o_req_ready), 64'd1);
    @(negedge clk);
    chk("bp single resp", 64'(o_resp_valid), 64'd0);

    // Reset while waiting for memory drops the transaction
    @(negedge clk);
    t_req_valid = 1'b1; t_we = 1'b0; t_f3 = F3_W; t_addr = 32'h3000;
    @(negedge clk);
    t_req_valid = 1'b0;
    t_mem_req_ready = 1'b1;
    @(negedge clk);
    t_mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst req_ready", 64'(o_req_ready), 64'd1);
    chk("rst resp_valid", 64'(o_resp_valid), 64'd0);
    chk("rst mem_req_valid", 64'(o_mem_req_valid), 64'd0);
    t_mem_resp_valid = 1'b1;
    t_mem_rdata = 64'h12345678;
    @(negedge clk);
    t_mem_resp_valid = 1'b0;
    chk("rst stale resp ignored", 64'(o_resp_valid), 64'd0);
    run_vec(mk("post_rst_lw", 0, 0, F3_W, 32'h3000, 0, 64'hCAFEF00D, 64'hCAFEF00D, 0, 1, 0, 8'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
